// File: rtl/swan_kat_sequencer.sv
// Known-answer self-test sequencer for serial SWAN encrypt/decrypt cores.
// Walks an external vector ROM, drives each core through start/ready, and tallies mismatches.
module swan_kat_sequencer #(
    parameter int unsigned BLOCK_SIZE = 64,
    parameter int unsigned KEY_SIZE   = 256,
    parameter int unsigned NUM_VEC    = 3,
    parameter int unsigned TIMEOUT    = 1023,
    parameter int unsigned CHECK_DEC  = 1,
    parameter int unsigned IW         = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1,
    parameter int unsigned CW         = IW + 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CW-1:0]         err_count,
    output logic [IW-1:0]         first_fail,
    output logic                  timeout_err,
    output logic [IW-1:0]         vec_idx,
    input  logic [KEY_SIZE-1:0]   vec_key,
    input  logic [BLOCK_SIZE-1:0] vec_pt,
    input  logic [BLOCK_SIZE-1:0] vec_ct,
    output logic                  enc_start,
    output logic [BLOCK_SIZE-1:0] enc_inp,
    output logic [KEY_SIZE-1:0]   enc_key,
    input  logic                  enc_ready,
    input  logic [BLOCK_SIZE-1:0] enc_out,
    output logic                  dec_start,
    output logic [BLOCK_SIZE-1:0] dec_inp,
    output logic [KEY_SIZE-1:0]   dec_key,
    input  logic                  dec_ready,
    input  logic [BLOCK_SIZE-1:0] dec_out
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TmrLast = TW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LastIdx = IW'(NUM_VEC - 1);

    typedef enum logic [2:0] {
        StIdle, StLoad, StEncGo, StEncWait, StDecGo, StDecWait, StNext, StDone
    } state_e;

    state_e                state_q;
    logic [KEY_SIZE-1:0]   k_q;
    logic [BLOCK_SIZE-1:0] p_q;
    logic [BLOCK_SIZE-1:0] c_q;
    logic [TW-1:0]         tmr_q;

    logic enc_end, dec_end, fail_ev, tmo_ev;

    // A WAIT state ends on the first ready, or after TIMEOUT cycles without one.
    always_comb begin
        enc_end = (state_q == StEncWait) && (enc_ready || (tmr_q == TmrLast));
        dec_end = (state_q == StDecWait) && (dec_ready || (tmr_q == TmrLast));
        tmo_ev  = (enc_end && !enc_ready) || (dec_end && !dec_ready);
        fail_ev = (enc_end && (!enc_ready || (enc_out != c_q)))
               || (dec_end && (!dec_ready || (dec_out != p_q)));
    end

    assign pass = done && (err_count == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            k_q         <= '0;
            p_q         <= '0;
            c_q         <= '0;
            tmr_q       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_count   <= '0;
            first_fail  <= '0;
            timeout_err <= 1'b0;
            vec_idx     <= '0;
            enc_start   <= 1'b0;
            enc_inp     <= '0;
            enc_key     <= '0;
            dec_start   <= 1'b0;
            dec_inp     <= '0;
            dec_key     <= '0;
        end else begin
            enc_start <= 1'b0;
            dec_start <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (run) begin
                        state_q     <= StLoad;
                        err_count   <= '0;
                        first_fail  <= '0;
                        timeout_err <= 1'b0;
                        vec_idx     <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                StLoad: begin
                    k_q       <= vec_key;
                    p_q       <= vec_pt;
                    c_q       <= vec_ct;
                    enc_inp   <= vec_pt;
                    enc_key   <= vec_key;
                    enc_start <= 1'b1;
                    state_q   <= StEncGo;
                end
                StEncGo: begin
                    tmr_q   <= '0;
                    state_q <= StEncWait;
                end
                StEncWait: begin
                    if (enc_end) begin
                        if (CHECK_DEC != 0) begin
                            dec_inp   <= c_q;
                            dec_key   <= k_q;
                            dec_start <= 1'b1;
                            state_q   <= StDecGo;
                        end else begin
                            state_q <= StNext;
                        end
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                StDecGo: begin
                    tmr_q   <= '0;
                    state_q <= StDecWait;
                end
                StDecWait: begin
                    if (dec_end) begin
                        state_q <= StNext;
                    end else begin
                        tmr_q <= tmr_q + TW'(1);
                    end
                end
                StNext: begin
                    if (vec_idx == LastIdx) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        vec_idx <= vec_idx + IW'(1);
                        state_q <= StLoad;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (fail_ev) begin
                if (err_count != '1) begin
                    err_count <= err_count + CW'(1);
                end
                if (err_count == '0) begin
                    first_fail <= vec_idx;
                end
            end
            if (tmo_ev) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_swan_kat_sequencer.sv
// Bench for swan_kat_sequencer: invertible stub cores with programmable latency,
// randomized vector tables, and an outcome model computed directly from the table.
module tb_swan_kat_sequencer;

    localparam int unsigned BS = 64;
    localparam int unsigned KS = 256;
    localparam int unsigned NV = 3;
    localparam int unsigned TO = 15;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    logic busy, done, pass, timeout_err, enc_start, dec_start, enc_ready, dec_ready;
    logic [CW-1:0] err_count;
    logic [IW-1:0] first_fail, vec_idx;
    logic [KS-1:0] vec_key, enc_key, dec_key;
    logic [BS-1:0] vec_pt, vec_ct, enc_inp, dec_inp, enc_out, dec_out;

    logic [KS-1:0] tkey [NV];
    logic [BS-1:0] tpt  [NV];
    logic [BS-1:0] tct  [NV];

    int  enc_lat = 3, dec_lat = 3;
    bit  enc_never = 1'b0, dec_never = 1'b0, spur = 1'b0;
    int  checks = 0, errors = 0;
    int  n_enc = 0, n_dec = 0, n_busy = 0;

    always #5 clk = ~clk;

    assign vec_key = tkey[vec_idx];
    assign vec_pt  = tpt[vec_idx];
    assign vec_ct  = tct[vec_idx];

    swan_kat_sequencer #(
        .BLOCK_SIZE(BS), .KEY_SIZE(KS), .NUM_VEC(NV), .TIMEOUT(TO), .CHECK_DEC(1)
    ) dut (
        .clk(clk), .rst(rst), .run(run), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail(first_fail), .timeout_err(timeout_err),
        .vec_idx(vec_idx), .vec_key(vec_key), .vec_pt(vec_pt), .vec_ct(vec_ct),
        .enc_start(enc_start), .enc_inp(enc_inp), .enc_key(enc_key),
        .enc_ready(enc_ready), .enc_out(enc_out),
        .dec_start(dec_start), .dec_inp(dec_inp), .dec_key(dec_key),
        .dec_ready(dec_ready), .dec_out(dec_out)
    );

    // Toy invertible cipher standing in for the real cores.
    function automatic logic [BS-1:0] f_enc(input logic [BS-1:0] x, input logic [KS-1:0] k);
        return {x[56:0], x[63:57]} ^ k[63:0] ^ k[255:192];
    endfunction

    function automatic logic [BS-1:0] f_dec(input logic [BS-1:0] y, input logic [KS-1:0] k);
        logic [BS-1:0] t;
        t = y ^ k[63:0] ^ k[255:192];
        return {t[6:0], t[63:7]};
    endfunction

    // Stub cores: ready rises L cycles after the start cycle and stays high (stale) until
    // the next start; output is garbage whenever ready is low.
    logic          erdy = 1'b0, drdy = 1'b0;
    int            ecnt = 0, dcnt = 0;
    logic [BS-1:0] ecap_p = '0, dcap_p = '0;
    logic [KS-1:0] ecap_k = '0, dcap_k = '0;

    always @(posedge clk) begin
        if (enc_start) begin
            ecap_p <= enc_inp;
            ecap_k <= enc_key;
            ecnt   <= 1;
            erdy   <= !enc_never && (enc_lat == 1);
        end else if (ecnt != 0 && !erdy) begin
            ecnt <= ecnt + 1;
            erdy <= !enc_never && (ecnt + 1 == enc_lat);
        end
        if (dec_start) begin
            dcap_p <= dec_inp;
            dcap_k <= dec_key;
            dcnt   <= 1;
            drdy   <= !dec_never && (dec_lat == 1);
        end else if (dcnt != 0 && !drdy) begin
            dcnt <= dcnt + 1;
            drdy <= !dec_never && (dcnt + 1 == dec_lat);
        end
    end

    assign enc_ready = erdy | (spur & enc_start);
    assign enc_out   = erdy ? f_enc(ecap_p, ecap_k) : ~f_enc(ecap_p, ecap_k);
    assign dec_ready = drdy;
    assign dec_out   = drdy ? f_dec(dcap_p, dcap_k) : ~f_dec(dcap_p, dcap_k);

    task automatic check(input string tag, input logic [KS-1:0] obs, input logic [KS-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (enc_start) n_enc++;
        if (dec_start) n_dec++;
        if (busy) n_busy++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".busy"}, KS'(busy), '0);
        check({tag, ".done"}, KS'(done), '0);
        check({tag, ".pass"}, KS'(pass), '0);
        check({tag, ".err_count"}, KS'(err_count), '0);
        check({tag, ".first_fail"}, KS'(first_fail), '0);
        check({tag, ".timeout_err"}, KS'(timeout_err), '0);
        check({tag, ".vec_idx"}, KS'(vec_idx), '0);
        check({tag, ".enc_start"}, KS'(enc_start), '0);
        check({tag, ".dec_start"}, KS'(dec_start), '0);
        check({tag, ".enc_inp"}, KS'(enc_inp), '0);
        check({tag, ".enc_key"}, enc_key, '0);
        check({tag, ".dec_inp"}, KS'(dec_inp), '0);
        check({tag, ".dec_key"}, dec_key, '0);
    endtask

    task automatic build_table(input logic [NV-1:0] corrupt);
        for (int i = 0; i < int'(NV); i++) begin
            tkey[i] = {$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom(), $urandom()};
            tpt[i]  = {$urandom(), $urandom()};
            tct[i]  = f_enc(tpt[i], tkey[i]);
            if (corrupt[i]) tct[i] = tct[i] ^ (64'd1 << $urandom_range(63, 0));
        end
    endtask

    // Full sequence against the outcome model; optional ignored run pulse mid-sequence.
    task automatic run_seq(input string tag, input logic [NV-1:0] corrupt, input int elat,
                           input int dlat, input bit en, input bit dn, input bit sp,
                           input bit ghost);
        int exp_err, exp_first, exp_cyc;
        bit found, exp_tmo, ef, df;
        enc_lat = elat; dec_lat = dlat; enc_never = en; dec_never = dn; spur = sp;
        build_table(corrupt);
        exp_err = 0; exp_first = 0; exp_cyc = 0; found = 0;
        for (int i = 0; i < int'(NV); i++) begin
            ef = en || (f_enc(tpt[i], tkey[i]) != tct[i]);
            df = dn || (f_dec(tct[i], tkey[i]) != tpt[i]);
            exp_err += int'(ef) + int'(df);
            if ((ef || df) && !found) begin
                found = 1'b1;
                exp_first = i;
            end
            exp_cyc += 2 + (en ? int'(TO) : elat) + 1 + (dn ? int'(TO) : dlat) + 1;
        end
        if (exp_err > 15) exp_err = 15;
        exp_tmo = en || dn;

        n_enc = 0; n_dec = 0; n_busy = 0;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            run = ghost && (c == 6);
            tick();
        end
        run = 1'b0;
        check({tag, ".done"}, KS'(done), KS'(1));
        check({tag, ".busy"}, KS'(busy), '0);
        check({tag, ".pass"}, KS'(pass), KS'(exp_err == 0));
        check({tag, ".err_count"}, KS'(err_count), KS'(exp_err));
        check({tag, ".first_fail"}, KS'(first_fail), KS'(exp_first));
        check({tag, ".timeout_err"}, KS'(timeout_err), KS'(exp_tmo));
        check({tag, ".busy_cycles"}, KS'(n_busy), KS'(exp_cyc));
        check({tag, ".enc_pulses"}, KS'(n_enc), KS'(NV));
        check({tag, ".dec_pulses"}, KS'(n_dec), KS'(NV));
        for (int c = 0; c < 3; c++) tick();
        check({tag, ".done_hold"}, KS'(done), KS'(1));
        check({tag, ".err_hold"}, KS'(err_count), KS'(exp_err));
    endtask

    initial begin
        for (int i = 0; i < int'(NV); i++) begin
            tkey[i] = '0; tpt[i] = '0; tct[i] = '0;
        end
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();

        run_seq("clean", 3'b000, 3, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq("bad_v1", 3'b010, 2, 2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_seq("dec_timeout", 3'b000, 2, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_seq("spurious", 3'b000, 4, 4, 1'b0, 1'b0, 1'b1, 1'b0);
        run_seq("ghost_run", 3'b000, 3, 3, 1'b0, 1'b0, 1'b0, 1'b1);
        run_seq("lat1", 3'b100, 1, 1, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset in DEC_WAIT of vector 1, then a clean rerun.
        enc_lat = 3; dec_lat = 3; enc_never = 1'b0; dec_never = 1'b0; spur = 1'b0;
        build_table(3'b000);
        n_enc = 0; n_dec = 0;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int c = 0; c < 500 && n_dec < 2; c++) tick();
        check("abort.reach_dec1", KS'(n_dec), KS'(2));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all_zero("abort");
        n_enc = 0; n_dec = 0;
        for (int c = 0; c < 30; c++) tick();
        check("abort.no_enc", KS'(n_enc), '0);
        check("abort.no_dec", KS'(n_dec), '0);
        run_seq("after_abort", 3'b000, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0);

        // run coincident with rst: reset wins.
        rst = 1'b1;
        run = 1'b1;
        tick();
        rst = 1'b0;
        run = 1'b0;
        tick();
        check("rst_vs_run.busy", KS'(busy), '0);
        check("rst_vs_run.done", KS'(done), '0);

        for (int r = 0; r < 8; r++) begin
            run_seq($sformatf("rand%0d", r), 3'($urandom_range(7, 0)),
                    int'($urandom_range(8, 1)), int'($urandom_range(8, 1)),
                    ($urandom_range(4, 0) == 0), ($urandom_range(3, 0) == 0),
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/swan_kat_sequencer.md
# swan_kat_sequencer

Self-checking known-answer-test (KAT) sequencer for the serial SWAN encrypt/decrypt cores. On a `run` pulse it walks a parametrised table of key/plaintext/ciphertext vectors supplied by an external ROM. For each vector it drives the serial encrypt core, and optionally the decrypt core, through a start/ready handshake, then compares the outputs. It sits beside a `serial_SWAN<B>K<K>_ENC`/`_DEC` pair as the synthesizable power-on self-test, and it is generic over block width, key width and vector count.

## Interface
Parameters:
- `BLOCK_SIZE`, default 64: cipher block width in bits.
- `KEY_SIZE`, default 256: key width in bits.
- `NUM_VEC`, default 3: number of vectors in the external table; must be at least 1.
- `TIMEOUT`, default 1023: maximum cycles to wait for a core `ready` before declaring a timeout.
- `CHECK_DEC`, default 1: 1 runs the decrypt check per vector; 0 skips it.
- `IW` (derived) = max(1, clog2(NUM_VEC)).
- `CW` (derived) = IW+2.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `run`  in  1  one-cycle start request.
- `busy`  out  1  high while a sequence is in progress.
- `done`  out  1  high from sequence end until the next accepted `run` or `rst`.
- `pass`  out  1  valid while `done`=1; high iff `err_count`==0.
- `err_count`  out  CW  number of failed checks, timeouts included.
- `first_fail`  out  IW  index of the first failing vector.
- `timeout_err`  out  1  sticky; set by any timeout in the current sequence.
- `vec_idx`  out  IW  ROM address.
- `vec_key`  in  KEY_SIZE  key for `vec_idx`; ROM is combinational.
- `vec_pt`  in  BLOCK_SIZE  plaintext for `vec_idx`.
- `vec_ct`  in  BLOCK_SIZE  expected ciphertext for `vec_idx`.
- `enc_start`, `dec_start`  out  1  one-cycle start to the core.
- `enc_inp`, `dec_inp`  out  BLOCK_SIZE  block to the core.
- `enc_key`, `dec_key`  out  KEY_SIZE  key to the core.
- `enc_ready`, `dec_ready`  in  1  core result valid.
- `enc_out`, `dec_out`  in  BLOCK_SIZE  core result.

## Operation
- States: IDLE, LOAD, ENC_GO, ENC_WAIT, DEC_GO, DEC_WAIT, NEXT, DONE.
- IDLE or DONE with `run`=1 → LOAD:
  - clears `err_count`, `first_fail`, `timeout_err` and `vec_idx`;
  - sets `busy`=1 and `done`=0.
- `run` is ignored in every other state.
- LOAD: registers `vec_key`, `vec_pt` and `vec_ct` into internal K, P, C. Next state is ENC_GO.
- ENC_GO: `enc_start`=1 for exactly this cycle, with `enc_inp`=P and `enc_key`=K. Next state is ENC_WAIT with the wait counter cleared.
- ENC_WAIT: the counter increments each cycle.
  - First cycle with `enc_ready`=1: compare `enc_out` against C. On mismatch, record a failure.
  - Counter reaches TIMEOUT without ready: record a failure and set `timeout_err`.
  - Either way, go to DEC_GO if CHECK_DEC=1, otherwise to NEXT.
- DEC_GO and DEC_WAIT behave the same with `dec_inp`=C and `dec_key`=K, and compare against P. The decrypt input is the table ciphertext, not `enc_out`, so the two checks are independent.
- Recording a failure:
  - `err_count` increments, saturating at all-ones.
  - If this is the first failure of the sequence, `first_fail` takes `vec_idx`. A vector failing both checks sets `first_fail` once.
- NEXT:
  - If `vec_idx`==NUM_VEC-1 → DONE with `busy`=0 and `done`=1.
  - Otherwise `vec_idx` increments and the state goes to LOAD.
- `enc_inp`, `enc_key`, `dec_inp` and `dec_key` stay constant from the GO cycle until the WAIT state exits.
- `enc_ready`/`dec_ready` are ignored outside their own WAIT state, including during the GO cycle. A stale ready is never taken as a result.

## Timing
- Reset values:
  - all outputs are 0, including `*_inp`/`*_key`;
  - state is IDLE.
- Reset mid-sequence aborts on the next edge. No further `*_start` pulse is issued, and results are discarded.
- Per vector with a core latency of L cycles (ready seen L cycles after the start cycle):
  - encrypt phase takes 1 (LOAD) + 1 (GO) + L cycles;
  - decrypt phase adds 1 + L cycles;
  - NEXT takes 1 cycle.
- With a timeout, a WAIT state lasts exactly TIMEOUT cycles.
- `done`, `pass`, `err_count` and `first_fail` are final in the first cycle of DONE and hold until a new `run` or `rst`.
- `run` in the same cycle as `rst`: reset wins.

## Test plan
- Real 64/256 cores, 3-vector table, NUM_VEC=3, CHECK_DEC=1:
  - vector 0: key 0, pt 0x8877665544332211, ct 0x3249d350bc89337c;
  - vector 1: key all-1 nibbles, pt 0xefcdab9078563412, ct 0x15cebc3b6e457d2b;
  - vector 2: key all-F, pt 0xf0debc9a78563412, ct 0xb57ffcf7a5449b9a;
  - required: `done`=1, `pass`=1, `err_count`=0, `timeout_err`=0, and exactly 3 `enc_start` and 3 `dec_start` pulses.
- Same table with vector 1 ct changed to 0x15cebc3b6e457d2a → `err_count`=2 (its enc and dec checks both fail), `first_fail`=1, `pass`=0.
- Decrypt core stubbed to never assert ready, TIMEOUT=15 → each DEC_WAIT lasts 15 cycles, `err_count`=3, `timeout_err`=1, `first_fail`=0.
- Spurious `enc_ready` held high through ENC_GO against a stub of latency 4 → the compare uses the output sampled in ENC_WAIT, and the result is correct.
- `run` pulsed while `busy`=1 → ignored, and the sequence length is unchanged.
- `rst` asserted in DEC_WAIT of vector 1 → all outputs 0 next cycle. A following `run` completes with `pass`=1.
